// File: rtl/onchip_memory_arbiter_pkg.sv
// Shared constants for the two-master on-chip RAM arbiter.
package onchip_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 40000;

    localparam int M0 = 0;
    localparam int M1 = 1;

    localparam logic [31:0] BAD_READ_VAL_DEF = 32'h0000_0000;

endpackage

// File: rtl/onchip_memory_arbiter_if.sv
// Avalon-MM pipelined master port with fixed read latency 1.
interface onchip_memory_arbiter_if
    import onchip_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/onchip_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic; no grant at all while in reset.
module rr_arbiter2
    import onchip_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       reset_n,
    output logic [1:0] gnt
);

    // A lone requester always wins; on a tie the master that did not win last time wins.
    always_comb begin
        gnt = 2'b00;
        if (reset_n) begin
            if (req == 2'b11) begin
                if (last_grant) begin
                    gnt[M0] = 1'b1;
                end else begin
                    gnt[M1] = 1'b1;
                end
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters with round-robin
// fairness, range checking and a sticky first-error record.
module onchip_memory_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter logic [DATA_W-1:0] BAD_READ_VAL = DATA_W'(BAD_READ_VAL_DEF)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    onchip_memory_arbiter_if.slave m0,
    onchip_memory_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  err_flag,
    output logic [ADDR_W-1:0]     err_addr,
    input  logic                  err_clear
);

    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                last_grant;
    logic [1:0]          rd_pend;
    logic                rd_oor;
    logic                any_gnt;
    logic                sel;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W/8-1:0] sel_be;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_read;
    logic                sel_write;
    logic                in_range;
    logic                rd_accept;
    logic                new_err;
    logic [DATA_W-1:0]   rsp_data;

    assign req[M0] = m0.read | m0.write;
    assign req[M1] = m1.read | m1.write;

    rr_arbiter2 u_arb (
        .req        (req),
        .last_grant (last_grant),
        .reset_n    (reset_n),
        .gnt        (gnt)
    );

    assign any_gnt = |gnt;
    assign sel     = gnt[M1];

    assign m0.waitrequest = req[M0] & ~gnt[M0];
    assign m1.waitrequest = req[M1] & ~gnt[M1];

    // Route the granted master onto the RAM side; master 0 is parked there when idle.
    always_comb begin
        sel_addr  = m0.address;
        sel_be    = m0.byteenable;
        sel_wdata = m0.writedata;
        sel_read  = m0.read;
        sel_write = m0.write;
        if (sel) begin
            sel_addr  = m1.address;
            sel_be    = m1.byteenable;
            sel_wdata = m1.writedata;
            sel_read  = m1.read;
            sel_write = m1.write;
        end
    end

    assign in_range  = (32'(sel_addr) < DEPTH);
    assign rd_accept = any_gnt & sel_read & ~sel_write;
    assign new_err   = any_gnt & (~in_range | (sel_read & sel_write));

    assign mem_address    = sel_addr;
    assign mem_byteenable = sel_be;
    assign mem_writedata  = sel_wdata;
    assign mem_chipselect = any_gnt & in_range;
    assign mem_write      = any_gnt & sel_write & in_range;
    assign mem_clken      = reset_n;

    assign rsp_data         = rd_oor ? BAD_READ_VAL : mem_readdata;
    assign m0.readdata      = rsp_data;
    assign m1.readdata      = rsp_data;
    assign m0.readdatavalid = rd_pend[M0];
    assign m1.readdatavalid = rd_pend[M1];

    // Remember the last winner and which master owes a read response next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            rd_pend    <= 2'b00;
            rd_oor     <= 1'b0;
        end else begin
            if (any_gnt) begin
                last_grant <= sel;
            end
            rd_pend <= rd_accept ? gnt : 2'b00;
            rd_oor  <= rd_accept & ~in_range;
        end
    end

    // Sticky error record: first error address is kept, a clear beats a same-cycle error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_flag <= 1'b0;
            err_addr <= '0;
        end else if (err_clear) begin
            err_flag <= 1'b0;
            err_addr <= '0;
        end else if (new_err && !err_flag) begin
            err_flag <= 1'b1;
            err_addr <= sel_addr;
        end
    end

endmodule
